// File: rtl/img_sram_sequencer_if.sv
// Shared SRAM control type and the job/sub-controller bundle of img_sram_sequencer.
package img_sram_pkg;
    typedef struct packed {
        logic        cs;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } img_sram_ctrl_t;
endpackage

interface img_sram_sequencer_if;
    import img_sram_pkg::*;

    logic           start;
    logic           abort;
    logic           conv_bypass;
    logic [7:0]     nrows_in;
    logic [7:0]     ncols_in;
    logic [7:0]     nrows;
    logic [7:0]     ncols;
    logic           sub_rstn;
    logic           rx_en;
    logic           tx_en;
    logic           conv_en;
    logic           rx_busy;
    logic           tx_busy;
    logic           conv_busy;
    img_sram_ctrl_t rx_sram_ctrl;
    img_sram_ctrl_t tx_sram_ctrl;
    img_sram_ctrl_t conv_sram_ctrl;
    img_sram_ctrl_t sram_ctrl;
    logic [1:0]     phase;
    logic           busy;
    logic           done;
    logic           error;

    modport master (
        output start, abort, conv_bypass, nrows_in, ncols_in,
        output rx_busy, tx_busy, conv_busy,
        output rx_sram_ctrl, tx_sram_ctrl, conv_sram_ctrl,
        input  nrows, ncols, sub_rstn, rx_en, tx_en, conv_en,
        input  sram_ctrl, phase, busy, done, error
    );

    modport slave (
        input  start, abort, conv_bypass, nrows_in, ncols_in,
        input  rx_busy, tx_busy, conv_busy,
        input  rx_sram_ctrl, tx_sram_ctrl, conv_sram_ctrl,
        output nrows, ncols, sub_rstn, rx_en, tx_en, conv_en,
        output sram_ctrl, phase, busy, done, error
    );
endinterface

// File: rtl/img_sram_sequencer.sv
// Phase controller for the shared image SRAM: runs RX -> CONV (optional) -> TX,
// owns the single SRAM port and supervises each sub-controller with a watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no job; waits for start
// RX_GO     | one-cycle rx_en pulse, RX owns SRAM
// RX_WAIT   | RX owns SRAM; wait busy rise, then busy fall
// GAP1      | SRAM undriven for ownership handover after RX
// CV_GO     | one-cycle conv_en pulse, CONV owns SRAM
// CV_WAIT   | CONV owns SRAM; wait busy rise, then busy fall
// GAP2      | SRAM undriven for ownership handover after CONV
// TX_GO     | one-cycle tx_en pulse, TX owns SRAM
// TX_WAIT   | TX owns SRAM; wait busy rise, then busy fall
// FIN       | done pulse
// ABORT     | one cycle of sub-controller reset, then IDLE without done
module img_sram_sequencer
    import img_sram_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int RISE_WAIT  = 4,
    parameter int TIMEOUT_W  = 20
) (
    input logic clk,
    input logic rstn,
    img_sram_sequencer_if.slave bus
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_RX_GO   = 4'd1;
    localparam logic [3:0] S_RX_WAIT = 4'd2;
    localparam logic [3:0] S_GAP1    = 4'd3;
    localparam logic [3:0] S_CV_GO   = 4'd4;
    localparam logic [3:0] S_CV_WAIT = 4'd5;
    localparam logic [3:0] S_GAP2    = 4'd6;
    localparam logic [3:0] S_TX_GO   = 4'd7;
    localparam logic [3:0] S_TX_WAIT = 4'd8;
    localparam logic [3:0] S_FIN     = 4'd9;
    localparam logic [3:0] S_ABORT   = 4'd10;

    // Shared down-counter: watchdog in x_WAIT (loaded full), gap timer in GAPx.
    // Rise limit: no busy seen by the (RISE_WAIT-1)th WAIT cycle, so the error
    // is visible RISE_WAIT cycles after the en pulse.
    localparam logic [TIMEOUT_W-1:0] TMR_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] TMR_ONE  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] RISE_TC  = TMR_MAX - TIMEOUT_W'(RISE_WAIT - 2);
    localparam logic [TIMEOUT_W-1:0] GAP_LOAD = TIMEOUT_W'(GAP_CYCLES - 1);

    logic [3:0]           state, state_nxt;
    logic [TIMEOUT_W-1:0] tmr;
    logic                 seen;
    logic                 error_q;
    logic                 bypass_q;
    logic [7:0]           nrows_q, ncols_q;
    logic                 sub_rel_q;

    logic in_go, in_wait, in_gap, nxt_go, nxt_gap;
    logic own_busy, dims_zero, accept, wd_err, busy_fall;

    // Decode the current phase and the owning controller's busy flag.
    always_comb begin
        in_go    = (state == S_RX_GO)   || (state == S_CV_GO)   || (state == S_TX_GO);
        in_wait  = (state == S_RX_WAIT) || (state == S_CV_WAIT) || (state == S_TX_WAIT);
        in_gap   = (state == S_GAP1)    || (state == S_GAP2);
        own_busy = 1'b0;
        case (state)
            S_RX_WAIT: own_busy = bus.rx_busy;
            S_CV_WAIT: own_busy = bus.conv_busy;
            S_TX_WAIT: own_busy = bus.tx_busy;
            default:   own_busy = 1'b0;
        endcase
        dims_zero = (bus.nrows_in == 8'd0) || (bus.ncols_in == 8'd0);
        accept    = (state == S_IDLE) && bus.start && !dims_zero;
        wd_err    = in_wait && ((!seen && !own_busy && tmr == RISE_TC) || tmr == '0);
        busy_fall = in_wait && seen && !own_busy;
    end

    // Next-state: abort and watchdog errors override normal sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_RX_GO;
            S_RX_GO:   state_nxt = S_RX_WAIT;
            S_RX_WAIT: if (busy_fall) state_nxt = S_GAP1;
            S_GAP1:    if (tmr == '0) state_nxt = bypass_q ? S_TX_GO : S_CV_GO;
            S_CV_GO:   state_nxt = S_CV_WAIT;
            S_CV_WAIT: if (busy_fall) state_nxt = S_GAP2;
            S_GAP2:    if (tmr == '0) state_nxt = S_TX_GO;
            S_TX_GO:   state_nxt = S_TX_WAIT;
            S_TX_WAIT: if (busy_fall) state_nxt = S_FIN;
            S_FIN:     state_nxt = S_IDLE;
            S_ABORT:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (wd_err || (bus.abort && state != S_IDLE && state != S_ABORT))
            state_nxt = S_ABORT;
        nxt_go  = (state_nxt == S_RX_GO) || (state_nxt == S_CV_GO) || (state_nxt == S_TX_GO);
        nxt_gap = (state_nxt == S_GAP1)  || (state_nxt == S_GAP2);
    end

    // State, timer, rise tracking, error flag and latched job parameters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            tmr       <= '0;
            seen      <= 1'b0;
            error_q   <= 1'b0;
            bypass_q  <= 1'b0;
            nrows_q   <= 8'd0;
            ncols_q   <= 8'd0;
            sub_rel_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            sub_rel_q <= 1'b1;
            if (nxt_go)
                tmr <= TMR_MAX;
            else if (nxt_gap && !in_gap)
                tmr <= GAP_LOAD;
            else if (in_wait || in_gap)
                tmr <= tmr - TMR_ONE;
            if (nxt_go)
                seen <= 1'b0;
            else if (in_wait && own_busy)
                seen <= 1'b1;
            if (state == S_IDLE && bus.start)
                error_q <= dims_zero;
            else if (wd_err)
                error_q <= 1'b1;
            if (accept) begin
                bypass_q <= bus.conv_bypass;
                nrows_q  <= bus.nrows_in;
                ncols_q  <= bus.ncols_in;
            end
        end
    end

    // Outputs decoded from state; the SRAM mux only forwards the current owner.
    always_comb begin
        bus.sub_rstn = sub_rel_q && (state != S_ABORT);
        bus.rx_en    = (state == S_RX_GO);
        bus.conv_en  = (state == S_CV_GO);
        bus.tx_en    = (state == S_TX_GO);
        bus.busy     = (state != S_IDLE);
        bus.done     = (state == S_FIN);
        bus.error    = error_q;
        bus.nrows    = nrows_q;
        bus.ncols    = ncols_q;
        bus.phase    = 2'd0;
        bus.sram_ctrl = '0;
        case (state)
            S_RX_GO, S_RX_WAIT: begin
                bus.phase     = 2'd1;
                bus.sram_ctrl = bus.rx_sram_ctrl;
            end
            S_CV_GO, S_CV_WAIT: begin
                bus.phase     = 2'd2;
                bus.sram_ctrl = bus.conv_sram_ctrl;
            end
            S_TX_GO, S_TX_WAIT: begin
                bus.phase     = 2'd3;
                bus.sram_ctrl = bus.tx_sram_ctrl;
            end
            default: begin
                bus.phase     = 2'd0;
                bus.sram_ctrl = '0;
            end
        endcase
    end

endmodule
